// File: rtl/axo_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the regfile
// write port.
interface axo_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic [4:0]      req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [4:0]      req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_din;
  logic            busy;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_rd, rf_din, busy
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_rd, rf_din, busy
  );
endinterface

// File: rtl/axo_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port; zero-fills x1..x31
// after reset before granting any requester.
module axo_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  axo_wb_arbiter_if.slave   bus
);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_ARB   = 1'b1;

  logic [0:0]      r_state;
  logic [4:0]      r_idx;
  logic            r_last;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_din;

  logic w_arb, w_gnt0, w_gnt1;

  // On a tie the requester that was not granted last wins, so r_last=1 at
  // reset hands the first tie to req0.
  assign w_arb  = (r_state == S_ARB);
  assign w_gnt0 = w_arb && bus.req0_valid && (!bus.req1_valid ||  r_last);
  assign w_gnt1 = w_arb && bus.req1_valid && (!bus.req0_valid || !r_last);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_CLEAR;
      r_idx   <= 5'd1;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_rd    <= 5'd0;
      r_din   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_we  <= 1'b1;
      r_rd  <= r_idx;
      r_din <= '0;
      r_idx <= r_idx + 5'd1;
      if (r_idx == 5'd31) r_state <= S_ARB;
    end else if (w_gnt0) begin
      // A write to x0 is consumed but never reaches the regfile.
      r_we   <= (bus.req0_rd != 5'd0);
      r_rd   <= bus.req0_rd;
      r_din  <= bus.req0_data;
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_we   <= (bus.req1_rd != 5'd0);
      r_rd   <= bus.req1_rd;
      r_din  <= bus.req1_data;
      r_last <= 1'b1;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rf_we      = r_we;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_din     = r_din;
  assign bus.busy       = !i_rst_n || (r_state == S_CLEAR);
endmodule

// File: doc/axo_wb_arbiter.md
Name: axo_wb_arbiter

Overview:
- Owns the single write port of the XLEN-bit integer register file.
- Shares that port between two write-back requesters: req0 (execute/ALU/CSR results) and req1 (load unit).
- After reset, sequences a zero-fill of x1..x31 through the same port before accepting requests.
- Sits between the pipeline write-back stages and the regfile's rd/we/din inputs.

Parameters:
XLEN, 32, width of write data and regfile entries.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
req0_valid  input  1  requester 0 has a write pending.
req0_rd  input  5  requester 0 destination register.
req0_data  input  XLEN  requester 0 write data.
req0_ready  output  1  requester 0 granted this cycle.
req1_valid  input  1  requester 1 has a write pending.
req1_rd  input  5  requester 1 destination register.
req1_data  input  XLEN  requester 1 write data.
req1_ready  output  1  requester 1 granted this cycle.
rf_we  output  1  regfile write enable (registered).
rf_rd  output  5  regfile write index (registered).
rf_din  output  XLEN  regfile write data (registered).
busy  output  1  high while resetting or zero-filling.

Behaviour:
- State machine: CLEAR and ARB. Reset forces CLEAR, clear index idx=1, round-robin pointer last=1, rf_we=0, rf_rd=0, rf_din=0.
- busy is 1 while rst_n=0 and in CLEAR; 0 in ARB.
- Reset asserted at any time, including mid-CLEAR or with a write in flight:
  - takes effect at that edge;
  - any pending registered write is dropped (rf_we=0);
  - clearing restarts at idx=1.
- CLEAR, on each edge with rst_n=1:
  - rf_we<=1, rf_rd<=idx, rf_din<=0, idx<=idx+1;
  - the edge that writes idx=31 moves state to ARB;
  - exactly 31 consecutive writes, x1 first, x0 never written;
  - req0_ready=req1_ready=0 throughout.
- ARB grant logic (combinational, depends only on valids, state and last):
  - only req0_valid: grant 0;
  - only req1_valid: grant 1;
  - both valid: grant the requester != last (req0 wins the first tie after reset);
  - neither valid: no grant.
- reqN_ready=1 only for the granted requester. Requesters must not make valid depend on ready. A handshake is valid&&ready in the same cycle.
- Handshake on requester g at edge E:
  - rf_rd<=reqg_rd, rf_din<=reqg_data, last<=g;
  - rf_we<=1 unless reqg_rd==0, in which case rf_we<=0 and the request is consumed (dropped) with last still updated.
- Latency: the write is visible on rf_* in the cycle after the handshake and is committed by the regfile at the following edge.
- Throughput: one write per cycle, no bubbles.
- No handshake in ARB at an edge: rf_we<=0; rf_rd and rf_din hold their previous values.
- Starvation bound: with both requesters continuously valid, grants strictly alternate, so a waiting requester is granted within 1 cycle.
- The block does not check that the two requesters target the same rd. Each accepted write is forwarded in grant order.
- rd and data are sampled only at the handshake edge; they may change freely otherwise.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release:
  - during reset: rf_we=0, busy=1;
  - edges 1..31 after release: rf_we=1, rf_rd=1..31 in order, rf_din=0, readies 0;
  - edge 31 enters ARB; busy=0 from edge 31 onward.
- ARB, req0 only, rd=5, data=0xDEADBEEF for one cycle:
  - req0_ready=1 that cycle;
  - next cycle rf_we=1, rf_rd=5, rf_din=0xDEADBEEF;
  - following cycle rf_we=0.
- Both requesters valid for 4 cycles (req0 rd=1 data=0x11, req1 rd=2 data=0x22), first tie after reset:
  - grant order 0,1,0,1;
  - rf_rd sequence 1,2,1,2 with no idle cycles.
- req1 valid with rd=0, data=0x55:
  - req1_ready=1, next cycle rf_we=0;
  - a following tie with req0 grants req0 (last=1).
- Pull rst_n=0 at CLEAR idx=17, release after 1 cycle:
  - clearing restarts at rf_rd=1 and completes all 31 writes.
- Pull rst_n=0 in the cycle after a handshake:
  - the next cycle shows rf_we=0 and busy=1.
